// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Brief    : Fetch-PC owner and {pc, instr} FIFO between ROM and decode.
// Revision : 1.0
// ============================================================================
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fetch_en,
  output logic [31:0]              rom_addr,
  input  logic [31:0]              rom_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic w_pop_req;
  logic w_pop;
  logic w_full;
  logic w_push;

  // A redirect discards the head, so the raw handshake only frees a slot
  // for a same-cycle push; it never moves the read pointer under redirect.
  assign w_pop_req = id_valid & id_ready;
  assign w_pop     = w_pop_req & ~redirect_valid;
  assign w_full    = (count_q == CW'(DEPTH));
  assign w_push    = fetch_en & ~redirect_valid & (~w_full | w_pop_req);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (w_push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= rom_data;
    end
  end

  assign rom_addr = fetch_pc_q;
  assign q_count  = count_q;
  assign id_valid = (count_q != '0);
  assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q]    : 32'd0;
  assign id_instr = id_valid ? instr_mem_q[rd_ptr_q] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Brief    : Directed bench for instr_fetch_queue with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  q_count;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .q_count        (q_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a[31:2] == 30'd0) return 32'h0011_0233;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fetch PC plus an ordered list of {pc, instr}; head is element 0.
  logic [31:0] m_pc;
  logic [63:0] m_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 32'h0;
      m_q.delete();
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      bit pop;
      bit push;
      pop  = (m_q.size() != 0) && id_ready;
      push = fetch_en && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 64'd0;
    check("rom_addr", rom_addr, m_pc);
    check("id_valid", {31'd0, id_valid}, {31'd0, m_q.size() != 0});
    check("q_count",  {29'd0, q_count}, m_q.size());
    check("id_pc",    id_pc,    head[63:32]);
    check("id_instr", id_instr, head[31:0]);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fetch_en = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    fetch_en = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    #1;
    check("reset_valid", {31'd0, id_valid}, 32'd0);
    check("reset_addr", rom_addr, 32'd0);

    // Streaming from reset with decode always ready.
    do_reset();
    fetch_en = 1'b1;
    id_ready = 1'b1;
    check("c0_addr", rom_addr, 32'd0);
    tick();
    check("c1_valid", {31'd0, id_valid}, 32'd1);
    check("c1_pc", id_pc, 32'd0);
    check("c1_instr", id_instr, 32'h0011_0233);
    tick();
    check("c2_pc", id_pc, 32'd4);
    tick();
    check("c3_pc", id_pc, 32'd8);
    tick();
    check("c4_pc", id_pc, 32'd12);

    // Fill to saturation, then drain while still pushing.
    do_reset();
    fetch_en = 1'b1;
    tick(6);
    check("sat_count", {29'd0, q_count}, 32'd4);
    check("sat_addr", rom_addr, 32'd16);
    id_ready = 1'b1;
    tick(3);
    check("full_count", {29'd0, q_count}, 32'd4);
    check("full_addr", rom_addr, 32'd28);
    check("full_head", id_pc, 32'd12);
    tick(3);

    // Redirect with three entries queued.
    do_reset();
    fetch_en = 1'b1;
    tick(3);
    check("pre_redir_count", {29'd0, q_count}, 32'd3);
    redirect_valid = 1'b1;
    redirect_pc = 32'd52;
    id_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("redir_count", {29'd0, q_count}, 32'd0);
    check("redir_valid", {31'd0, id_valid}, 32'd0);
    check("redir_addr", rom_addr, 32'd52);
    tick();
    check("redir_head", id_pc, 32'd52);
    tick(2);

    // Misaligned JALR target.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_005A;
    tick();
    redirect_valid = 1'b0;
    check("jalr_addr", rom_addr, 32'h58);
    tick();
    check("jalr_head", id_pc, 32'h58);

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc = 32'd100;
    tick();
    redirect_pc = 32'd200;
    tick();
    redirect_valid = 1'b0;
    check("b2b_addr", rom_addr, 32'd200);
    tick(2);

    // Redirect while fetch is disabled, then resume.
    fetch_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    tick(2);
    check("idle_addr", rom_addr, 32'h40);
    check("idle_count", {29'd0, q_count}, 32'd0);
    fetch_en = 1'b1;
    id_ready = 1'b0;
    tick(3);
    fetch_en = 1'b0;
    id_ready = 1'b1;
    tick(4);
    check("drain_count", {29'd0, q_count}, 32'd0);
    check("drain_addr", rom_addr, 32'h4C);

    // Asynchronous reset between edges with two entries queued.
    do_reset();
    fetch_en = 1'b1;
    id_ready = 1'b0;
    tick(2);
    fetch_en = 1'b0;
    check("pre_rst_count", {29'd0, q_count}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, id_valid}, 32'd0);
    check("arst_count", {29'd0, q_count}, 32'd0);
    check("arst_addr", rom_addr, 32'd0);
    tick();
    reset_n = 1'b1;
    fetch_en = 1'b1;
    id_ready = 1'b1;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Instruction fetch controller between the PC/branch logic and the instruction ROM (combinational read: word index = addr[31:2]). It owns the fetch PC and issues one ROM address per cycle while there is room. It buffers {pc, instr} pairs in a small FIFO so decode stalls do not force a ROM re-read. It accepts redirects from branch/JAL/JALR resolution and flushes all wrong-path entries.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
RESET_PC, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
fetch_en  input  1  1 = fetch may issue ROM reads; 0 = hold fetch_pc, queue still drains
rom_addr  output  32  byte address to ROM (equals fetch_pc)
rom_data  input  32  ROM word for rom_addr, valid same cycle
redirect_valid  input  1  taken branch/jump; flush and restart
redirect_pc  input  32  redirect target byte address
id_ready  input  1  decode accepts head entry this cycle (0 = hazard stall)
id_valid  output  1  head entry valid
id_instr  output  32  head instruction
id_pc  output  32  head instruction PC
q_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset_n low, async): fetch_pc=RESET_PC; rd_ptr=wr_ptr=0; count=0. Outputs: id_valid=0, q_count=0, rom_addr=RESET_PC, id_instr=0, id_pc=0. Storage contents are don't-care; id_instr and id_pc are forced to 0 while count==0.
- rom_addr = fetch_pc, combinational.
- pop = id_valid & id_ready.
- push = fetch_en & ~redirect_valid & (count<DEPTH | pop). Full with a same-cycle pop still pushes.
- On push, at the clock edge:
  - entry[wr_ptr] <= {fetch_pc, rom_data};
  - wr_ptr increments and wraps modulo DEPTH;
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
- On pop: rd_ptr increments and wraps modulo DEPTH.
- count <= count + push - pop. Simultaneous push and pop leaves count unchanged.
- Head outputs: id_valid = (count!=0); id_instr and id_pc come from entry[rd_ptr], combinational from registers.
- Empty queue: id_valid=0. A push on an empty queue becomes visible at the next cycle, so fetch-to-decode latency is 1 cycle.
- Full queue with no pop: no push, fetch_pc holds, rom_addr is stable.
- Redirect has priority over everything. In the assertion cycle:
  - no push;
  - the pop handshake is ignored (the entry is discarded);
  - at the edge: count=0, rd_ptr=wr_ptr=0, fetch_pc <= {redirect_pc[31:2],2'b00}.
  - The target is fetched the next cycle and appears on id_* 2 cycles after redirect assertion.
- Back-to-back redirects: the last one wins; each one clears the queue.
- Redirect while fetch_en=0: the queue is flushed and fetch_pc is loaded; issue waits for fetch_en.
- fetch_en=0: fetch_pc frozen; pops continue until empty.
- Reset asserted mid-operation: immediate return to reset values; no partial entry survives.
- Ordering: entries leave in the order fetched. id_pc of consecutive pops differs by exactly 4 unless a redirect occurred between them.

Test Plan:
- Reset release, id_ready=1, ROM word0=32'h0011_0233 (add x4,x2,x1) -> rom_addr=0 in cycle 0; id_valid=1, id_pc=0, id_instr=32'h0011_0233 in cycle 1; then PCs 4, 8, 12 on consecutive cycles.
- id_ready=0 for 6 cycles from reset -> q_count climbs 1,2,3,4 and saturates at 4; rom_addr holds at 16. Raise id_ready -> PCs 0,4,8,12,16 pop in order, with no bubble at 16.
- Full queue with id_ready=1 -> push and pop in the same cycle; q_count stays 4; rom_addr advances by 4 each cycle.
- redirect_valid with redirect_pc=52 (beq to word 13) while q_count=3 -> q_count=0 next cycle; rom_addr=52; id_valid=0 for 1 cycle; then id_pc=52. No id_pc 44 or 48 is ever popped.
- redirect_pc=32'h0000_005A (misaligned, JALR) -> fetch resumes at 88 (0x58).
- reset_n pulsed low asynchronously between edges with q_count=2 -> id_valid and q_count drop to 0 immediately; rom_addr=RESET_PC.
